// File: rtl/multicycle_controller_pkg.sv
// Shared opcode map, state encoding and datapath select codes for the
// multi-cycle fetch/decode/execute controller.
package multicycle_controller_pkg;

   localparam logic [7:0] OP_ADD   = 8'h05;
   localparam logic [7:0] OP_SUB   = 8'h09;
   localparam logic [7:0] OP_CMP   = 8'h0B;
   localparam logic [7:0] OP_AND   = 8'h01;
   localparam logic [7:0] OP_OR    = 8'h02;
   localparam logic [7:0] OP_XOR   = 8'h03;
   localparam logic [7:0] OP_MOV   = 8'h0D;
   localparam logic [7:0] OP_ADDI  = 8'h50;
   localparam logic [7:0] OP_SUBI  = 8'h90;
   localparam logic [7:0] OP_CMPI  = 8'hB0;
   localparam logic [7:0] OP_ANDI  = 8'h10;
   localparam logic [7:0] OP_ORI   = 8'h20;
   localparam logic [7:0] OP_XORI  = 8'h30;
   localparam logic [7:0] OP_MOVI  = 8'hD0;
   localparam logic [7:0] OP_LSH   = 8'h84;
   localparam logic [7:0] OP_LSHI0 = 8'h80;
   localparam logic [7:0] OP_LSHI1 = 8'h81;
   localparam logic [7:0] OP_LUI   = 8'hF0;
   localparam logic [7:0] OP_LOAD  = 8'h40;
   localparam logic [7:0] OP_STOR  = 8'h44;
   localparam logic [7:0] OP_JAL   = 8'h48;
   localparam logic [7:0] OP_JCOND = 8'h4C;
   localparam logic [7:0] OP_BCOND = 8'hC0;

   typedef enum logic [4:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_SHIFT,
      S_LUI1,
      S_LUI2,
      S_LOAD_REQ,
      S_LOAD_WB,
      S_STOR_REQ,
      S_STOR_DONE,
      S_JAL_LINK,
      S_JUMP,
      S_BRANCH,
      S_ILLEGAL,
      S_FAULT
   } state_e;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;

   localparam logic [2:0] BUS_ALU   = 3'b000;
   localparam logic [2:0] BUS_SHIFT = 3'b001;
   localparam logic [2:0] BUS_IMM   = 3'b010;
   localparam logic [2:0] BUS_MEM   = 3'b011;
   localparam logic [2:0] BUS_LINK  = 3'b100;
   localparam logic [2:0] BUS_STORE = 3'b101;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       flag_write;
      logic       reg_write;
      logic       is_mov;
   } alu_ctl_t;

   // JCOND has no execute state of its own; it reuses JUMP for its single
   // pcJump cycle.
   function automatic state_e decode_state(input logic [7:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR, OP_MOV:       return S_EXEC_R;
         OP_ADDI, OP_SUBI, OP_CMPI, OP_ANDI, OP_ORI, OP_XORI, OP_MOVI: return S_EXEC_I;
         OP_LSH, OP_LSHI0, OP_LSHI1: return S_SHIFT;
         OP_LUI:   return S_LUI1;
         OP_LOAD:  return S_LOAD_REQ;
         OP_STOR:  return S_STOR_REQ;
         OP_JAL:   return S_JAL_LINK;
         OP_JCOND: return S_JUMP;
         OP_BCOND: return S_BRANCH;
         default:  return S_ILLEGAL;
      endcase
   endfunction

   function automatic alu_ctl_t alu_decode(input logic [7:0] op);
      alu_ctl_t c;
      c = '0;
      case (op)
         OP_ADD, OP_ADDI: c = '{alu_op: ALU_ADD, flag_write: 1'b1, reg_write: 1'b1, is_mov: 1'b0};
         OP_SUB, OP_SUBI: c = '{alu_op: ALU_SUB, flag_write: 1'b1, reg_write: 1'b1, is_mov: 1'b0};
         OP_CMP, OP_CMPI: c = '{alu_op: ALU_SUB, flag_write: 1'b1, reg_write: 1'b0, is_mov: 1'b0};
         OP_AND, OP_ANDI: c = '{alu_op: ALU_AND, flag_write: 1'b1, reg_write: 1'b1, is_mov: 1'b0};
         OP_OR,  OP_ORI:  c = '{alu_op: ALU_OR,  flag_write: 1'b1, reg_write: 1'b1, is_mov: 1'b0};
         OP_XOR, OP_XORI: c = '{alu_op: ALU_XOR, flag_write: 1'b1, reg_write: 1'b1, is_mov: 1'b0};
         OP_MOV, OP_MOVI: c = '{alu_op: ALU_ADD, flag_write: 1'b0, reg_write: 1'b1, is_mov: 1'b1};
         default:         c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Counts memory wait states for the current request and flags a timeout
// once MAX_WAIT waits have elapsed with ready still low.
module mem_wait_timer
   import multicycle_controller_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic timeout
);

   logic [7:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && count != 8'hFF) begin
         count <= count + 8'd1;
      end
   end

   assign timeout = enable && (count == 8'(MAX_WAIT));

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle fetch/decode/execute controller with a bounded memory
// handshake, fetch stall, illegal-opcode skip and sticky bus fault.
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int OPW      = 8,
   parameter int MAX_WAIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] instruction,
   input  logic [OPW-1:0]   instructionOp,
   input  logic             mem_ready,
   input  logic             stall,
   output logic             mem_req,
   output logic             fetchPhase,
   output logic [3:0]       ALUOp,
   output logic [1:0]       shiftOp,
   output logic [2:0]       busOp,
   output logic             immMUX,
   output logic             regWrite,
   output logic             memWrite,
   output logic             flagWrite,
   output logic             LUIOp,
   output logic             pcAdd,
   output logic             pcJump,
   output logic             pcBranch,
   output logic             illegal_op,
   output logic             bus_fault
);

   state_e     state, state_next;
   logic [7:0] op;
   alu_ctl_t   alu_ctl;
   logic       req_active;
   logic       wait_en;
   logic       timeout;
   logic       unused_instruction;

   assign op                 = 8'(instructionOp);
   assign alu_ctl            = alu_decode(op);
   assign unused_instruction = ^instruction;

   // Request qualifier kept apart from the output decode so the timer
   // feedback into next-state logic has no combinational loop.
   assign req_active = reset && (((state == S_FETCH) && !stall) ||
                                 (state == S_LOAD_REQ) || (state == S_STOR_REQ));
   assign wait_en    = req_active && !mem_ready;

   mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state_next != state),
      .enable  (wait_en),
      .timeout (timeout)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_FETCH;
         bus_fault <= 1'b0;
      end else begin
         state <= state_next;
         if (timeout) bus_fault <= 1'b1;
      end
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case can infer a latch.
      state_next = state;
      mem_req    = 1'b0;
      fetchPhase = 1'b0;
      ALUOp      = ALU_ADD;
      shiftOp    = 2'b00;
      busOp      = BUS_ALU;
      immMUX     = 1'b0;
      regWrite   = 1'b0;
      memWrite   = 1'b0;
      flagWrite  = 1'b0;
      LUIOp      = 1'b0;
      pcAdd      = 1'b0;
      pcJump     = 1'b0;
      pcBranch   = 1'b0;
      illegal_op = 1'b0;
      // Held reset forces every output low, including a FETCH request.
      if (reset) begin
         case (state)
            S_FETCH: begin
               if (!stall) begin
                  mem_req = 1'b1;
                  if (mem_ready) begin
                     fetchPhase = 1'b1;
                     state_next = S_DECODE;
                  end else if (timeout) begin
                     state_next = S_FAULT;
                  end
               end
            end
            S_DECODE: state_next = decode_state(op);
            S_EXEC_R, S_EXEC_I: begin
               ALUOp      = alu_ctl.alu_op;
               flagWrite  = alu_ctl.flag_write;
               regWrite   = alu_ctl.reg_write;
               busOp      = alu_ctl.is_mov ? BUS_IMM : BUS_ALU;
               immMUX     = (state == S_EXEC_I);
               pcAdd      = 1'b1;
               state_next = S_FETCH;
            end
            S_SHIFT: begin
               busOp      = BUS_SHIFT;
               regWrite   = 1'b1;
               pcAdd      = 1'b1;
               immMUX     = (op != OP_LSH);
               state_next = S_FETCH;
            end
            S_LUI1: begin
               immMUX     = 1'b1;
               busOp      = BUS_IMM;
               regWrite   = 1'b1;
               state_next = S_LUI2;
            end
            S_LUI2: begin
               LUIOp      = 1'b1;
               immMUX     = 1'b1;
               busOp      = BUS_SHIFT;
               regWrite   = 1'b1;
               pcAdd      = 1'b1;
               state_next = S_FETCH;
            end
            S_LOAD_REQ: begin
               mem_req = 1'b1;
               if (mem_ready)    state_next = S_LOAD_WB;
               else if (timeout) state_next = S_FAULT;
            end
            S_LOAD_WB: begin
               busOp      = BUS_MEM;
               regWrite   = 1'b1;
               pcAdd      = 1'b1;
               state_next = S_FETCH;
            end
            S_STOR_REQ: begin
               mem_req  = 1'b1;
               memWrite = 1'b1;
               busOp    = BUS_STORE;
               if (mem_ready)    state_next = S_STOR_DONE;
               else if (timeout) state_next = S_FAULT;
            end
            S_STOR_DONE: begin
               pcAdd      = 1'b1;
               state_next = S_FETCH;
            end
            S_JAL_LINK: begin
               busOp      = BUS_LINK;
               regWrite   = 1'b1;
               pcAdd      = 1'b1;
               state_next = S_JUMP;
            end
            S_JUMP: begin
               pcJump     = 1'b1;
               state_next = S_FETCH;
            end
            S_BRANCH: begin
               pcBranch   = 1'b1;
               immMUX     = 1'b1;
               state_next = S_FETCH;
            end
            S_ILLEGAL: begin
               illegal_op = 1'b1;
               pcAdd      = 1'b1;
               state_next = S_FETCH;
            end
            S_FAULT:  state_next = S_FAULT;
            default:  state_next = S_FETCH;
         endcase
      end
   end

endmodule
